mcdt_arbiter: RTL and testbench

Arbitration end of the MCDT slave-to-arbiter interface. Samples the request lines of three channel slave FIFOs and issues a one-cycle read acknowledge to one winner. It then captures the word and valid strobe the slave returns one cycle later and presents it, tagged with its channel ID, on a valid/ready output toward the formatter. At most one read is outstanding at any time.

---
 rtl/mcdt_arbiter_if.sv | 31 +++
 rtl/mcdt_arbiter.sv | 82 ++++++++
 tb/tb_mcdt_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcdt_arbiter_if.sv
// mcdt_arbiter_if: slave-FIFO read, channel enable and formatter handshake bundle of the MCDT arbiter.
interface mcdt_arbiter_if #(
    parameter int DW = 32
);
    logic          slv0_req_i, slv1_req_i, slv2_req_i;
    logic          slv0_val_i, slv1_val_i, slv2_val_i;
    logic [DW-1:0] slv0_data_i, slv1_data_i, slv2_data_i;
    logic          a2s0_ack_o, a2s1_ack_o, a2s2_ack_o;
    logic [2:0]    ch_en_i;
    logic          fmt_ready_i;
    logic          arb_val_o;
    logic [DW-1:0] arb_data_o;
    logic [1:0]    arb_id_o;
    logic          arb_err_o;
    modport master (
        input  slv0_req_i, slv1_req_i, slv2_req_i,
        input  slv0_val_i, slv1_val_i, slv2_val_i,
        input  slv0_data_i, slv1_data_i, slv2_data_i,
        input  ch_en_i, fmt_ready_i,
        output a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
        output arb_val_o, arb_data_o, arb_id_o, arb_err_o
    );
    modport slave (
        output slv0_req_i, slv1_req_i, slv2_req_i,
        output slv0_val_i, slv1_val_i, slv2_val_i,
        output slv0_data_i, slv1_data_i, slv2_data_i,
        output ch_en_i, fmt_ready_i,
        input  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
        input  arb_val_o, arb_data_o, arb_id_o, arb_err_o
    );
endinterface

// File: rtl/mcdt_arbiter.sv
// mcdt_arbiter: grants one of three slave FIFOs, captures the returned word and holds it on a valid/ready output.
// Define MCDT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority ch0 > ch1 > ch2.
module mcdt_arbiter #(
    parameter int NUM_CH = 3,
    parameter int DW     = 32
) (
    input logic            clk_i,
    input logic            rstn_i,
    mcdt_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;
    state_t            r_state, w_state;
    logic [NUM_CH-1:0] w_req, w_val, w_exp, w_ack, r_ack;
    logic [1:0]        w_win, r_win, r_id;
    logic [DW-1:0]     w_data, r_data;
    logic              w_go, w_take, w_bad, r_val, r_err;
    assign w_req  = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i} & bus.ch_en_i;
    assign w_val  = {bus.slv2_val_i, bus.slv1_val_i, bus.slv0_val_i};
    assign w_data = (r_win == 2'd2) ? bus.slv2_data_i : (r_win == 2'd1) ? bus.slv1_data_i : bus.slv0_data_i;
    // A word being consumed this edge frees the output, so a grant may overlap it.
    assign w_go   = (r_state == IDLE) && (|w_req) && (!r_val || bus.fmt_ready_i);
    assign w_exp  = (r_state == WAIT) ? NUM_CH'(1) << r_win : '0;
    assign w_take = (r_state == WAIT) && w_val[r_win];
    assign w_bad  = (|(w_val & ~w_exp)) || ((r_state == WAIT) && !w_val[r_win]);
`ifdef MCDT_ARB_RR_EN
    logic [1:0] r_last, w_c0, w_c1, w_c2;
    assign w_c0  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    assign w_c1  = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
    assign w_c2  = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    assign w_win = w_req[w_c0] ? w_c0 : w_req[w_c1] ? w_c1 : w_c2;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_last <= 2'd2;
        else if (w_go) r_last <= w_win;
    end
`else
    assign w_win = w_req[0] ? 2'd0 : w_req[1] ? 2'd1 : 2'd2;
`endif
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else r_state <= w_state;
    end
    always_comb begin
        w_state = r_state;
        w_ack   = '0;
        case (r_state)
            IDLE: begin
                w_state = w_go ? GRANT : IDLE;
                w_ack   = w_go ? NUM_CH'(1) << w_win : '0;
            end
            GRANT:   w_state = WAIT;
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ack  <= '0;
            r_win  <= 2'd0;
            r_val  <= 1'b0;
            r_data <= '0;
            r_id   <= 2'd0;
            r_err  <= 1'b0;
        end else begin
            r_ack <= w_ack;
            if (w_go) r_win <= w_win;
            if (w_take) begin
                r_val  <= 1'b1;
                r_data <= w_data;
                r_id   <= r_win;
            end else if (bus.fmt_ready_i) begin
                r_val <= 1'b0;
            end
            if (w_bad) r_err <= 1'b1;
        end
    end
    assign bus.a2s0_ack_o = r_ack[0];
    assign bus.a2s1_ack_o = r_ack[1];
    assign bus.a2s2_ack_o = r_ack[2];
    assign bus.arb_val_o  = r_val;
    assign bus.arb_data_o = r_data;
    assign bus.arb_id_o   = r_id;
    assign bus.arb_err_o  = r_err;
endmodule

// File: tb/tb_mcdt_arbiter.sv
// tb_mcdt_arbiter: random and directed stimulus checked every cycle against a transaction-timing reference model.
module tb_mcdt_arbiter;
    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    mcdt_arbiter_if #(.DW(32)) bus ();
    mcdt_arbiter #(.NUM_CH(3), .DW(32)) dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));

    logic [2:0]  t_req = '0, t_en = 3'b111, t_val = '0, t_hold = '0, t_spur = '0, t_seen = '0;
    logic        t_rdy = 1'b1;
    logic [31:0] t_data [3];
    logic [2:0]  d_ack;

    assign bus.slv0_req_i  = t_req[0];
    assign bus.slv1_req_i  = t_req[1];
    assign bus.slv2_req_i  = t_req[2];
    assign bus.slv0_val_i  = t_val[0];
    assign bus.slv1_val_i  = t_val[1];
    assign bus.slv2_val_i  = t_val[2];
    assign bus.slv0_data_i = t_data[0];
    assign bus.slv1_data_i = t_data[1];
    assign bus.slv2_data_i = t_data[2];
    assign bus.ch_en_i     = t_en;
    assign bus.fmt_ready_i = t_rdy;
    assign d_ack = {bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o};

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: a read is granted at edge g, its ack is visible after g, data is due at edge g+2.
    int          m_e = 0, m_gnt_e = -10, m_win = 0, m_last = 2, m_oid = 0;
    logic        m_oval = 1'b0, m_err = 1'b0;
    logic [31:0] m_odata = '0;
    logic [2:0]  m_ack = '0;

    function automatic int pick(input logic [2:0] r);
`ifdef MCDT_ARB_RR_EN
        for (int k = 1; k <= 3; k++) if (r[2'((m_last + k) % 3)]) return (m_last + k) % 3;
`else
        for (int k = 0; k < 3; k++) if (r[2'(k)]) return k;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_gnt_e = m_e - 10;
        m_win   = 0;
        m_last  = 2;
        m_oid   = 0;
        m_oval  = 1'b0;
        m_err   = 1'b0;
        m_odata = '0;
        m_ack   = '0;
    endtask

    task automatic model_step();
        int         e;
        logic [2:0] req;
        logic       due, nval;
        e    = m_e + 1;
        req  = t_req & t_en;
        due  = (e == m_gnt_e + 2);
        nval = m_oval;
        for (int i = 0; i < 3; i++)
            if (t_val[2'(i)] && !(due && i == m_win)) m_err = 1'b1;
        if (m_oval && t_rdy) nval = 1'b0;
        if (due) begin
            if (t_val[2'(m_win)]) begin
                nval    = 1'b1;
                m_odata = t_data[2'(m_win)];
                m_oid   = m_win;
            end else begin
                m_err = 1'b1;
            end
        end
        if (e > m_gnt_e + 2 && (!m_oval || t_rdy) && req != 3'b000) begin
            m_win   = pick(req);
            m_last  = m_win;
            m_gnt_e = e;
        end
        m_oval = nval;
        m_ack  = (m_gnt_e == e) ? 3'b001 << m_win : 3'b000;
        m_e    = e;
    endtask

    // Called at a falling edge: drive the slave response, advance model and DUT one clock, compare.
    task automatic tick();
        t_val  = (t_seen & ~t_hold) | t_spur;
        t_seen = d_ack;
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        check("ack", 32'(d_ack), 32'(m_ack));
        check("val", 32'(bus.arb_val_o), 32'(m_oval));
        if (m_oval) begin
            check("data", bus.arb_data_o, m_odata);
            check("id", 32'(bus.arb_id_o), m_oid);
        end
        check("err", 32'(bus.arb_err_o), 32'(m_err));
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        #1;
        check("rst_ack", 32'(d_ack), 0);
        check("rst_val", 32'(bus.arb_val_o), 0);
        check("rst_data", bus.arb_data_o, 0);
        check("rst_id", 32'(bus.arb_id_o), 0);
        check("rst_err", 32'(bus.arb_err_o), 0);
        model_reset();
        t_seen = '0;
        t_val  = '0;
        t_spur = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic drain();
        t_req = '0;
        t_rdy = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    int ids[$];
    int exp_ord[6];
    int cnt[3];
    int a1, id1, words;
    logic [31:0] hd;
    int hi;

    initial begin
`ifdef MCDT_ARB_RR_EN
        exp_ord = '{0, 1, 2, 0, 1, 2};
`else
        exp_ord = '{0, 0, 1, 1, 2, 2};
`endif
        for (int i = 0; i < 3; i++) t_data[i] = '0;
        @(negedge clk_i);
        do_reset();

        // single word from ch1
        t_req = 3'b010;
        t_data[1] = 32'hA5A5_0001;
        tick();
        check("t1_ack", 32'(d_ack), 32'h2);
        t_req = '0;
        tick();
        check("t1_ack_off", 32'(d_ack), 0);
        tick();
        check("t1_val", 32'(bus.arb_val_o), 1);
        check("t1_data", bus.arb_data_o, 32'hA5A5_0001);
        check("t1_id", 32'(bus.arb_id_o), 1);
        drain();

        // two words per channel, all requesting
        do_reset();
        cnt = '{2, 2, 2};
        for (int c = 0; c < 60 && ids.size() < 6; c++) begin
            t_req = {cnt[2] != 0, cnt[1] != 0, cnt[0] != 0};
            for (int i = 0; i < 3; i++) t_data[i] = $urandom;
            tick();
            for (int i = 0; i < 3; i++) if (d_ack[2'(i)]) cnt[i]--;
            if (bus.arb_val_o) ids.push_back(int'(bus.arb_id_o));
        end
        check("order_n", 32'(ids.size()), 6);
        for (int k = 0; k < 6; k++)
            check("order", (k < ids.size()) ? 32'(ids[k]) : 32'hFFFF, 32'(exp_ord[k]));
        drain();

        // backpressure with a held word
        t_rdy = 1'b0;
        t_req = 3'b111;
        for (int c = 0; c < 20 && !bus.arb_val_o; c++) tick();
        check("bp_held", 32'(bus.arb_val_o), 1);
        hd = bus.arb_data_o;
        hi = int'(bus.arb_id_o);
        repeat (10) begin
            tick();
            check("bp_data", bus.arb_data_o, hd);
            check("bp_id", 32'(bus.arb_id_o), hi);
            check("bp_noack", 32'(d_ack), 0);
        end
        t_rdy = 1'b1;
        tick();
        check("bp_ack_after", 32'(d_ack != 3'b000), 1);
        drain();

        // ch1 masked
        t_en = 3'b101;
        t_req = 3'b111;
        a1 = 0; id1 = 0; words = 0;
        repeat (40) begin
            for (int i = 0; i < 3; i++) t_data[i] = $urandom;
            tick();
            a1 += int'(d_ack[1]);
            if (bus.arb_val_o) begin
                words++;
                if (bus.arb_id_o == 2'd1) id1++;
            end
        end
        check("en_ack1", 32'(a1), 0);
        check("en_id1", 32'(id1), 0);
        check("en_words", 32'(words > 0), 1);
        t_en = 3'b111;
        drain();

        // val withheld in WAIT
        t_hold = 3'b111;
        t_req = 3'b001;
        tick();
        t_req = '0;
        tick();
        tick();
        check("hold_err", 32'(bus.arb_err_o), 1);
        check("hold_val", 32'(bus.arb_val_o), 0);
        t_hold = '0;
        repeat (4) tick();
        check("hold_sticky", 32'(bus.arb_err_o), 1);
        do_reset();

        // val on a non-granted channel
        t_spur = 3'b100;
        tick();
        t_spur = '0;
        check("spur_err", 32'(bus.arb_err_o), 1);
        repeat (3) tick();

        // reset while ack high, while in WAIT, and with a held word
        do_reset();
        t_req = 3'b111;
        tick();
        do_reset();
        tick();
        check("rst_first_ch0", 32'(d_ack), 32'h1);
        tick();
        do_reset();
        tick();
        check("rst_wait_ch0", 32'(d_ack), 32'h1);
        t_rdy = 1'b0;
        for (int c = 0; c < 10 && !bus.arb_val_o; c++) tick();
        check("rst_held", 32'(bus.arb_val_o), 1);
        do_reset();
        drain();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            t_req = 3'($urandom);
            if (c % 25 == 0) t_en = 3'($urandom);
            t_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) t_data[i] = $urandom;
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
